// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: fetch/decode/exec/mem/wb over a shared req/ack port.
// Strobes are decoded from registered state and latched fields; mem_req holds until mem_ack or timeout trap.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             branch_taken,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [3:0]       alu_ctrl,
  output logic             alu_src_b,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic [2:0]       state_o,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TMO     = 2'd2;
  localparam logic [1:0] CAUSE_ENV     = 2'd3;

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [6:0]       opcode_q, opcode_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [6:0]       funct7_q, funct7_d;
  logic [7:0]       tmo_q, tmo_d;
  logic             trap_q, trap_d;
  logic [1:0]       trap_cause_q, trap_cause_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc;
  logic op_legal;
  logic tmo_hit;
  logic retire;

  // Instruction class always comes from the latched opcode, never the live decoder output.
  assign is_r     = (opcode_q == OP_R);
  assign is_i     = (opcode_q == OP_I);
  assign is_ld    = (opcode_q == OP_LOAD);
  assign is_st    = (opcode_q == OP_STORE);
  assign is_br    = (opcode_q == OP_BRANCH);
  assign is_jal   = (opcode_q == OP_JAL);
  assign is_jalr  = (opcode_q == OP_JALR);
  assign is_lui   = (opcode_q == OP_LUI);
  assign is_auipc = (opcode_q == OP_AUIPC);

  always_comb begin
    op_legal = 1'b0;
    case (opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: op_legal = 1'b1;
      default:                           op_legal = 1'b0;
    endcase
  end

  // Limit hit only on the MEM_TIMEOUT-th unacked cycle; a same-cycle ack wins.
  assign tmo_hit = mem_req && !mem_ack && (tmo_q == TMO_LAST);

  assign retire = ((state_q == S_EXEC) && is_br) ||
                  ((state_q == S_MEM) && is_st && mem_ack) ||
                  (state_q == S_WB);

  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    funct3_d     = funct3_q;
    funct7_d     = funct7_q;
    trap_cause_d = trap_cause_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ack) begin
          state_d = S_DECODE;
        end else if (tmo_hit) begin
          state_d      = S_TRAP;
          trap_cause_d = CAUSE_TMO;
        end
      end
      S_DECODE: begin
        opcode_d = opcode;
        funct3_d = funct3;
        funct7_d = funct7;
        if (op_legal) begin
          state_d = S_EXEC;
        end else if (opcode == OP_SYSTEM) begin
          state_d      = S_TRAP;
          trap_cause_d = CAUSE_ENV;
        end else begin
          state_d      = S_TRAP;
          trap_cause_d = CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        if (is_ld || is_st)  state_d = S_MEM;
        else if (is_br)      state_d = S_FETCH;
        else                 state_d = S_WB;
      end
      S_MEM: begin
        if (mem_ack) begin
          state_d = is_ld ? S_WB : S_FETCH;
        end else if (tmo_hit) begin
          state_d      = S_TRAP;
          trap_cause_d = CAUSE_TMO;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    trap_d = trap_q || (state_d == S_TRAP);
    if (state_d != state_q)         tmo_d = 8'd0;
    else if (mem_req && !mem_ack)   tmo_d = tmo_q + 8'd1;
    else                            tmo_d = tmo_q;
    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      opcode_q     <= 7'd0;
      funct3_q     <= 3'd0;
      funct7_q     <= 7'd0;
      tmo_q        <= 8'd0;
      trap_q       <= 1'b0;
      trap_cause_q <= 2'd0;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      funct3_q     <= funct3_d;
      funct7_q     <= funct7_d;
      tmo_q        <= tmo_d;
      trap_q       <= trap_d;
      trap_cause_q <= trap_cause_d;
      retired_q    <= retired_d;
    end
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'd0;
    alu_ctrl     = 4'd0;
    alu_src_b    = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = 2'd0;
    // ALU setup is held from EXEC through MEM/WB so the registered result stays stable.
    if ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)) begin
      if (is_r) begin
        alu_ctrl  = {funct7_q[5], funct3_q};
        alu_src_b = 1'b0;
      end else if (is_i) begin
        alu_ctrl  = {(funct3_q == 3'b101) ? funct7_q[5] : 1'b0, funct3_q};
        alu_src_b = 1'b1;
      end else if (is_br) begin
        alu_ctrl  = 4'b1000;
      end else if (is_ld || is_st || is_jalr || is_auipc) begin
        alu_src_b = 1'b1;
      end
    end
    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ack;
      end
      S_EXEC: begin
        if (is_br) begin
          pc_write = 1'b1;
          pc_src   = branch_taken ? 2'd1 : 2'd0;
        end else if (is_jal) begin
          pc_src = 2'd1;
        end else if (is_jalr) begin
          pc_src = 2'd2;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_st;
        pc_write     = is_st && mem_ack;
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        if (is_ld)                 wb_sel = 2'd1;
        else if (is_jal || is_jalr) wb_sel = 2'd2;
        else if (is_lui)           wb_sel = 2'd3;
        if (is_jal)       pc_src = 2'd1;
        else if (is_jalr) pc_src = 2'd2;
      end
      default: ;
    endcase
  end

  assign state_o    = state_q;
  assign trap       = trap_q;
  assign trap_cause = trap_cause_q;
  assign retired    = retired_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control sequencer for the RV32I core.
- Drives instruction fetch and data access over a shared req/ack memory port.
- Latches the opcode/funct3/funct7 fields produced by the instruction field decoder.
- Issues per-state datapath strobes (PC, IR, ALU, register file, memory) and traps on illegal opcodes or memory timeouts.

Parameters:
- MEM_TIMEOUT, 16, max cycles mem_req may stay high without mem_ack before trapping (2..255).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk input 1: single clock; all state updates on the rising edge.
- rst_n input 1: asynchronous, active-low reset.
- start input 1: leave IDLE and begin fetching.
- opcode input 7: decoded instruction[6:0].
- funct3 input 3: decoded instruction[14:12].
- funct7 input 7: decoded instruction[31:25].
- branch_taken input 1: datapath comparator result, valid in EXEC.
- mem_ack input 1: memory completed the current request this cycle.
- mem_req output 1: memory request; held until ack.
- mem_we output 1: store request; valid with mem_req.
- mem_addr_sel output 1: 0 = PC, 1 = ALU result.
- ir_write output 1: load the instruction register.
- pc_write output 1: update the PC.
- pc_src output 2: 0 = PC+4, 1 = branch/JAL target, 2 = JALR target.
- alu_ctrl output 4: ALU operation.
- alu_src_b output 1: 0 = rs2, 1 = immediate.
- reg_write output 1: register file write enable.
- wb_sel output 2: 0 = ALU, 1 = load data, 2 = PC+4, 3 = immediate (LUI).
- state_o output 3: current state encoding.
- trap output 1: sticky error flag.
- trap_cause output 2: 1 = illegal opcode, 2 = memory timeout, 3 = ECALL/EBREAK.
- retired output CNT_W: count of completed instructions.

Behaviour:
- States and encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- Reset (async, rst_n=0):
  - state=IDLE, all strobes 0, trap=0, trap_cause=0, retired=0, latched fields 0, timeout counter 0.
  - Reset asserted mid-request drops mem_req immediately; no partial writes are issued.
- Output timing: all strobes are Moore outputs of state plus latched fields; there is no combinational path from opcode to outputs.
- IDLE:
  - Outputs idle.
  - start=1 → FETCH.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr_sel=0.
  - On mem_ack: ir_write pulses in that same cycle → DECODE.
- DECODE:
  - Latch opcode/funct3/funct7.
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111 → EXEC.
  - 1110011 → TRAP with cause 3.
  - Any other opcode → TRAP with cause 1.
- EXEC, by opcode class:
  - R-type: alu_ctrl={funct7[5],funct3}, alu_src_b=0 → WB.
  - I-ALU: alu_ctrl={funct3==101 ? funct7[5] : 0, funct3}, alu_src_b=1 → WB.
  - LOAD/STORE: alu_ctrl=0000, alu_src_b=1 → MEM.
  - BRANCH: alu_ctrl=1000 (SUB); pc_write=branch_taken, pc_src=1, otherwise pc_write=1 with pc_src=0; retire → FETCH.
  - JAL: pc_src=1 → WB. JALR: pc_src=2 → WB. In both cases the pc_write pulse is issued in WB, together with the link write.
  - LUI/AUIPC: alu_ctrl=0000 → WB.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we=1 for STORE.
  - On ack: LOAD → WB; STORE → pc_write (pc_src=0), retire → FETCH.
- WB:
  - reg_write=1; wb_sel: LOAD=1, JAL/JALR=2, LUI=3, otherwise 0.
  - pc_write=1 with pc_src = 0, 1 or 2 according to class.
  - Retire → FETCH.
- Retire:
  - retired increments by 1 on each completing cycle.
  - Wraps modulo 2^CNT_W.
- Timeout:
  - The counter clears on entry to FETCH/MEM and increments each cycle while mem_req=1 without ack.
  - When it reaches MEM_TIMEOUT with no ack → TRAP, cause 2.
  - An ack arriving in the same cycle the limit is reached wins (no trap).
- TRAP:
  - All strobes 0; trap=1 (sticky); trap_cause held.
  - Exit only by reset; start is ignored.
- mem_ack outside FETCH/MEM is ignored.
- The PC is never written in FETCH or DECODE.

Test Plan:
- Reset then start=1, ack one cycle after req, opcode=0110011, funct7=0100000, funct3=000 → states 1,2,3,5,1; alu_ctrl=1000 in EXEC; reg_write=1 and pc_write=1 in WB; retired=1.
- LOAD (0000011) with ack delayed 3 cycles in MEM → mem_req held high 4 cycles with mem_addr_sel=1; WB shows wb_sel=1; retired increments once.
- STORE (0100011) → MEM with mem_we=1; on ack pc_write=1, reg_write never asserted; return to FETCH.
- BRANCH: branch_taken=1 gives pc_src=1; branch_taken=0 gives pc_src=0; neither case writes a register.
- Opcode 0000000 → TRAP, trap_cause=1. Opcode 1110011 → trap_cause=3. With MEM_TIMEOUT=16 and ack never returned in FETCH → TRAP at cycle 16, cause 2. Ack on cycle 16 → DECODE, no trap.
- Assert rst_n=0 mid-MEM → mem_req falls with no clock edge; state=0 and retired=0 while reset is held.
